// File: rtl/me_pkg.sv
// me_pkg: state encoding and parameter defaults shared by the CTU motion-estimation scheduler.
package me_pkg;

  localparam int CTU_W_DEFAULT       = 7;
  localparam int WDOG_CYCLES_DEFAULT = 4095;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

endpackage

// File: rtl/ctu_me_wdog.sv
// ctu_me_wdog: counts RUN cycles since RUN entry and flags the cycle in which the limit is reached.
module ctu_me_wdog
  import me_pkg::*;
#(
  parameter int unsigned LIMIT = WDOG_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(LIMIT - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + ONE;
    end
  end

  // count holds completed RUN cycles, so the current cycle is the LIMIT-th one at LIMIT-1
  assign expired = run && (count == LIMIT_M1);

endmodule

// File: rtl/ctu_me_sched.sv
// ctu_me_sched: walks a frame in raster CTU order, sequencing load, PE-array search and result output.
// Defining CTU_ME_WDOG_EN adds a RUN-state watchdog that raises err_timeout and returns to IDLE.
module ctu_me_sched
  import me_pkg::*;
#(
  parameter int CTU_W       = CTU_W_DEFAULT,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [CTU_W-1:0] frame_w_ctu,
  input  logic [CTU_W-1:0] frame_h_ctu,
  input  logic             abort,
  output logic             load_req,
  input  logic             load_done,
  output logic             begin_prepare,
  input  logic             me_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CTU_W-1:0] ctu_x,
  output logic [CTU_W-1:0] ctu_y,
  output logic             busy,
  output logic             frame_done,
  output logic             err_timeout
);

  localparam logic [CTU_W-1:0] ONE = CTU_W'(1);

  logic [2:0]       state, state_nxt;
  logic [CTU_W-1:0] w_q, h_q, w_nxt, h_nxt;
  logic [CTU_W-1:0] x_nxt, y_nxt;
  logic             wdog_expired;

  always_comb begin
    state_nxt = state;
    w_nxt     = w_q;
    h_nxt     = h_q;
    x_nxt     = ctu_x;
    y_nxt     = ctu_y;
    case (state)
      ST_IDLE: begin
        if (frame_start && (frame_w_ctu != '0) && (frame_h_ctu != '0)) begin
          w_nxt     = frame_w_ctu;
          h_nxt     = frame_h_ctu;
          x_nxt     = '0;
          y_nxt     = '0;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:  if (load_done) state_nxt = ST_START;
      ST_START: state_nxt = ST_RUN;
      ST_RUN: begin
        if (me_done) state_nxt = ST_OUT;
        else if (wdog_expired) state_nxt = ST_IDLE;
      end
      ST_OUT:   if (res_ready) state_nxt = ST_NEXT;
      ST_NEXT: begin
        if (ctu_x < w_q - ONE) begin
          x_nxt     = ctu_x + ONE;
          state_nxt = ST_LOAD;
        end else begin
          x_nxt     = '0;
          y_nxt     = ctu_y + ONE;
          state_nxt = (ctu_y == h_q - ONE) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    // abort overrides every other event in a busy state
    if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      w_q           <= '0;
      h_q           <= '0;
      ctu_x         <= '0;
      ctu_y         <= '0;
      load_req      <= 1'b0;
      begin_prepare <= 1'b0;
      res_valid     <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_nxt;
      w_q           <= w_nxt;
      h_q           <= h_nxt;
      ctu_x         <= x_nxt;
      ctu_y         <= y_nxt;
      load_req      <= (state_nxt == ST_LOAD);
      begin_prepare <= (state_nxt == ST_START);
      res_valid     <= (state_nxt == ST_OUT);
      busy          <= (state_nxt != ST_IDLE);
      frame_done    <= (state_nxt == ST_DONE);
    end
  end

`ifdef CTU_ME_WDOG_EN
  logic wdog_clear, wdog_run;

  assign wdog_run   = (state == ST_RUN);
  assign wdog_clear = (state != ST_RUN) && (state_nxt == ST_RUN);

  ctu_me_wdog #(
    .LIMIT(WDOG_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wdog_clear),
    .run    (wdog_run),
    .expired(wdog_expired)
  );

  // me_done and abort both take precedence over a timeout in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_timeout <= 1'b0;
    else        err_timeout <= wdog_expired && !me_done && !abort;
  end
`else
  assign wdog_expired = 1'b0;
  assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_ctu_me_sched.sv
// tb_ctu_me_sched: scoreboard bench; stimulus pushes the expected raster CTU sequence and end event,
// a negedge monitor pops and compares on every result handshake, frame_done or err_timeout.
module tb_ctu_me_sched;

  localparam int CTU_W   = 7;
  localparam int EV_NONE = 0;
  localparam int EV_RES  = 1;
  localparam int EV_DONE = 2;
  localparam int EV_TMO  = 3;

  typedef struct {
    int kind;
    int x;
    int y;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frame_start;
  logic [CTU_W-1:0] frame_w_ctu, frame_h_ctu;
  logic             abort, load_done, me_done, res_ready;
  logic             load_req, begin_prepare, res_valid, busy, frame_done, err_timeout;
  logic [CTU_W-1:0] ctu_x, ctu_y;

  exp_t exp_q[$];
  int   n_vectors     = 0;
  int   n_miscompares = 0;

  always #5 clk = ~clk;

  ctu_me_sched #(
    .CTU_W      (CTU_W),
    .WDOG_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .frame_w_ctu  (frame_w_ctu),
    .frame_h_ctu  (frame_h_ctu),
    .abort        (abort),
    .load_req     (load_req),
    .load_done    (load_done),
    .begin_prepare(begin_prepare),
    .me_done      (me_done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .ctu_x        (ctu_x),
    .ctu_y        (ctu_y),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_timeout  (err_timeout)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkEvent(input int kind, input int x, input int y);
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("unexpected_event", kind, EV_NONE);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind", kind, e.kind);
      if (kind == EV_RES && e.kind == EV_RES) begin
        checkOutput("result_x", x, e.x);
        checkOutput("result_y", y, e.y);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && res_ready) checkEvent(EV_RES, int'(ctu_x), int'(ctu_y));
      if (frame_done)             checkEvent(EV_DONE, 0, 0);
      if (err_timeout)            checkEvent(EV_TMO, 0, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an accepted frame yields its CTUs in raster order, optionally cut short.
  task automatic applyStimulus(input int w, input int h, input int n_res, input int tail);
    frame_start = 1'b1;
    frame_w_ctu = CTU_W'(w);
    frame_h_ctu = CTU_W'(h);
    if (w > 0 && h > 0) begin
      for (int i = 0; i < n_res; i++) exp_q.push_back('{EV_RES, i % w, i / w});
      if (tail != EV_NONE) exp_q.push_back('{tail, 0, 0});
    end
  endtask

  task automatic waitFrameDone(input string name, input int max_cyc);
    int cyc = 0;
    while (!frame_done && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    checkOutput(name, int'(frame_done), 1);
    tick();
  endtask

  task automatic waitStart(input string name, input int max_cyc);
    int cyc = 0;
    while (!begin_prepare && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    checkOutput(name, int'(begin_prepare), 1);
  endtask

  task automatic runFrame(input int w, input int h);
    int cyc = 0;
    bit done = 1'b0;
    applyStimulus(w, h, w * h, EV_DONE);
    tick();
    frame_start = 1'b0;
    checkOutput("accept_load_req", int'(load_req), 1);
    checkOutput("accept_origin", int'({ctu_y, ctu_x}), 0);
    while (!done && cyc < 3000) begin
      if (frame_done) begin
        done = 1'b1;
      end else begin
        load_done   = ($urandom_range(0, 2) != 0);
        me_done     = ($urandom_range(0, 3) != 0);
        res_ready   = ($urandom_range(0, 2) != 0);
        frame_start = ($urandom_range(0, 4) == 0);
        frame_w_ctu = CTU_W'($urandom_range(0, 6));
        frame_h_ctu = CTU_W'($urandom_range(0, 6));
        tick();
        cyc++;
      end
    end
    frame_start = 1'b0;
    checkOutput("frame_complete", int'(done), 1);
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got still running, expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int cyc, bp, fd_cyc, stable, fd, busy_cnt, tmo_cnt;
    bit found;

    rst_n = 1'b0; frame_start = 1'b0; frame_w_ctu = '0; frame_h_ctu = '0;
    abort = 1'b0; load_done = 1'b0; me_done = 1'b0; res_ready = 1'b0;
    repeat (3) tick();
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_load_req", int'(load_req), 0);
    checkOutput("rst_begin_prepare", int'(begin_prepare), 0);
    checkOutput("rst_res_valid", int'(res_valid), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_err_timeout", int'(err_timeout), 0);
    checkOutput("rst_xy", int'({ctu_y, ctu_x}), 0);
    rst_n = 1'b1;
    tick();

    // 2x2 frame with zero-wait handshakes: latency and prepare pulse count
    load_done = 1'b1; me_done = 1'b1; res_ready = 1'b1;
    applyStimulus(2, 2, 4, EV_DONE);
    tick();
    frame_start = 1'b0;
    cyc = 1; bp = 0; fd_cyc = 0;
    while (fd_cyc == 0 && cyc < 100) begin
      if (begin_prepare) bp++;
      if (frame_done) fd_cyc = cyc;
      else begin
        tick();
        cyc++;
      end
    end
    checkOutput("zw_frame_done_cycle", fd_cyc, 21);
    checkOutput("zw_prepare_pulses", bp, 4);
    tick();
    checkOutput("zw_idle_after", int'(busy), 0);

    // 2x1 frame, stall the (1,0) result for 10 cycles
    applyStimulus(2, 1, 2, EV_DONE);
    tick();
    frame_start = 1'b0;
    cyc = 0;
    while (!(res_valid && ctu_x == 1) && cyc < 50) begin
      tick();
      cyc++;
    end
    res_ready = 1'b0;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid && ctu_x == 1 && ctu_y == 0) stable++;
      tick();
    end
    checkOutput("stall_stable_cycles", stable, 10);
    res_ready = 1'b1;
    tick();
    checkOutput("stall_next_res_valid", int'(res_valid), 0);
    checkOutput("stall_next_busy", int'(busy), 1);
    checkOutput("stall_next_not_load", int'(load_req), 0);
    checkOutput("stall_next_not_done", int'(frame_done), 0);
    tick();
    checkOutput("stall_done_after_next", int'(frame_done), 1);
    tick();

    // 3x1 frame aborted in RUN of (1,0), with a simultaneous me_done
    applyStimulus(3, 1, 1, EV_NONE);
    tick();
    frame_start = 1'b0;
    cyc = 0; found = 1'b0;
    while (!found && cyc < 50) begin
      if (begin_prepare && ctu_x == 1) found = 1'b1;
      else begin
        me_done = (ctu_x == 0);
        tick();
        cyc++;
      end
    end
    checkOutput("abort_reach_ctu1", int'(found), 1);
    me_done = 1'b0;
    tick();
    abort = 1'b1; me_done = 1'b1;
    tick();
    abort = 1'b0; me_done = 1'b1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_load_req", int'(load_req), 0);
    checkOutput("abort_res_valid", int'(res_valid), 0);
    fd = 0;
    repeat (6) begin
      if (frame_done) fd++;
      tick();
    end
    checkOutput("abort_no_frame_done", fd, 0);
    runFrame(3, 1);

    // zero dimensions in IDLE are ignored
    load_done = 1'b1; me_done = 1'b1; res_ready = 1'b1;
    applyStimulus(0, 3, 0, EV_NONE);
    tick();
    frame_start = 1'b0;
    checkOutput("zero_w_ignored", int'(busy), 0);
    applyStimulus(4, 0, 0, EV_NONE);
    tick();
    frame_start = 1'b0;
    checkOutput("zero_h_ignored", int'(busy), 0);

    // new dimensions during RUN must not change the 2x2 frame in progress
    me_done = 1'b0;
    applyStimulus(2, 2, 4, EV_DONE);
    tick();
    frame_start = 1'b0;
    waitStart("restart_reach_start", 20);
    tick();
    frame_start = 1'b1; frame_w_ctu = CTU_W'(1); frame_h_ctu = CTU_W'(1);
    tick();
    frame_start = 1'b0; me_done = 1'b1;
    waitFrameDone("restart_frame_done", 200);

    for (int k = 0; k < 12; k++) runFrame($urandom_range(1, 4), $urandom_range(1, 4));

    // reset mid-frame discards the frame
    applyStimulus(3, 3, 9, EV_DONE);
    tick();
    frame_start = 1'b0;
    repeat (12) begin
      load_done = $urandom_range(0, 1); me_done = $urandom_range(0, 1); res_ready = $urandom_range(0, 1);
      tick();
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_load_req", int'(load_req), 0);
    checkOutput("midrst_res_valid", int'(res_valid), 0);
    checkOutput("midrst_xy", int'({ctu_y, ctu_x}), 0);
    tick();
    rst_n = 1'b1;
    fd = 0;
    repeat (5) begin
      if (frame_done || busy) fd++;
      tick();
    end
    checkOutput("midrst_quiet", fd, 0);

`ifdef CTU_ME_WDOG_EN
    // watchdog expiry after 8 RUN cycles
    load_done = 1'b1; me_done = 1'b0; res_ready = 1'b1;
    applyStimulus(1, 1, 0, EV_TMO);
    tick();
    frame_start = 1'b0;
    waitStart("wd_reach_start", 20);
    busy_cnt = 0; tmo_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (err_timeout) tmo_cnt++;
    end
    checkOutput("wd_run_busy", busy_cnt, 8);
    checkOutput("wd_no_early_tmo", tmo_cnt, 0);
    tick();
    checkOutput("wd_tmo_pulse", int'(err_timeout), 1);
    checkOutput("wd_idle", int'(busy), 0);
    tick();
    checkOutput("wd_tmo_single", int'(err_timeout), 0);

    // me_done on the limit cycle wins over the timeout
    applyStimulus(1, 1, 1, EV_DONE);
    tick();
    frame_start = 1'b0;
    waitStart("wd_tie_reach_start", 20);
    repeat (8) tick();
    me_done = 1'b1;
    waitFrameDone("wd_tie_frame_done", 50);
`else
    // without the watchdog RUN waits indefinitely
    load_done = 1'b1; me_done = 1'b0; res_ready = 1'b1;
    applyStimulus(1, 1, 0, EV_NONE);
    tick();
    frame_start = 1'b0;
    busy_cnt = 0; tmo_cnt = 0;
    repeat (60) begin
      tick();
      if (busy) busy_cnt++;
      if (err_timeout) tmo_cnt++;
    end
    checkOutput("nowd_busy_held", busy_cnt, 60);
    checkOutput("nowd_no_tmo", tmo_cnt, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("nowd_abort_idle", int'(busy), 0);
`endif

    tick();
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
